modulo_captura_jogada: RTL and testbench
========================================

MODULO_CAPTURA_JOGADA -- requirements
Module: modulo_captura_jogada

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 250000; debounce window in clk cycles (5 ms at 50 MHz), legal range 2..2^20-1.
REQ-002 SHALL have port clk, input, 1, system clock; all state on rising edge.
REQ-003 SHALL have port clr, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port button_clk, input, 1, raw fire pushbutton, active-low (0 = pressed), asynchronous to clk.
REQ-005 SHALL have port button_clr, input, 1, raw clear pushbutton, active-low, asynchronous.
REQ-006 SHALL have port hh1, input, 2, mode switches, asynchronous.
REQ-007 SHALL have port hh2, input, 6, coordinate switches: [5:3] line, [2:0] column, asynchronous.
REQ-008 SHALL have port shot_ready, input, 1, downstream (attack-matrix stage) accepts shot.
REQ-009 SHALL have port shot_valid, output, 1, captured shot available.
REQ-010 SHALL have port shot_line, output, 3, captured line 0..6.
REQ-011 SHALL have port shot_col, output, 3, captured column 0..4.
REQ-012 SHALL have port shot_mode, output, 2, captured hh1.
REQ-013 SHALL have port err_coord, output, 1, one-cycle pulse: out-of-board coordinate rejected.
REQ-014 SHALL have port clr_pulse, output, 1, one-cycle pulse: debounced clear press.
REQ-015 SHALL have port shot_count, output, 4, accepted shots, saturating.

Function
REQ-016 SHALL pass button_clk, button_clr, hh1, hh2 each through a 2-flop synchronizer before any use.
REQ-017 SHALL debounce each synced button with its own counter: counter clears whenever synced level equals stable level; otherwise increments; stable level takes synced level when counter reaches DB_CYCLES-1, counter then clears.
REQ-018 SHALL generate a press event in the cycle the stable level goes 1->0; release = stable 0->1; no other events.
REQ-019 SHALL implement FSM states IDLE, VALID, WAIT_REL.
REQ-020 IDLE, fire press, synced line<=6 and col<=4: capture synced hh2/hh1 into shot_line/shot_col/shot_mode, go VALID; shot_valid=1 from the next cycle.
REQ-021 IDLE, fire press, line>6 or col>4: err_coord=1 for exactly the next cycle, no capture, go WAIT_REL.
REQ-022 VALID: shot_valid held 1, shot_line/shot_col/shot_mode stable until shot_valid&shot_ready sampled high.
REQ-023 On transfer: shot_valid=0 next cycle, shot_count increments (holds at 15), go WAIT_REL if fire stable still 0, else IDLE.
REQ-024 Fire presses while in VALID or WAIT_REL SHALL be ignored (no queuing).
REQ-025 WAIT_REL: go IDLE on the cycle fire stable level is 1.
REQ-026 Clear press SHALL, from the next cycle: clr_pulse=1 for one cycle, shot_valid=0, shot_count=0, FSM=IDLE, from any state.
REQ-027 Clear press and fire press same cycle: clear wins, fire press discarded.
REQ-028 Clear press and transfer same cycle: transfer counts as complete downstream, shot_count still becomes 0.
REQ-029 Switch changes in VALID SHALL NOT alter shot_line/shot_col/shot_mode.
REQ-030 Latency raw press to shot_valid SHALL be 2 + DB_CYCLES + 1 clk cycles (±1 for synchronizer phase).

Reset
REQ-031 clr=0 SHALL asynchronously force: FSM=IDLE, synchronizers and stable levels to 1 for buttons and to 0 for switches, debounce counters=0, all outputs 0.
REQ-032 Deassertion of clr SHALL NOT produce press events while buttons are held released.
REQ-033 clr asserted mid-VALID SHALL drop shot_valid immediately without a transfer or count change afterwards.

Verification (DB_CYCLES=4)
REQ-034 Reset: clr=0 with random inputs -> all outputs 0; release with buttons at 1 -> no pulses for 50 cycles.
REQ-035 hh2=6'b010_011, hh1=2'b01, fire held 0 for 12 cycles, shot_ready=1 -> single shot_valid cycle, shot_line=2, shot_col=3, shot_mode=1, shot_count=1.
REQ-036 Fire toggling every 2 cycles for 20 cycles then held 0 -> exactly one shot_valid; hh2=6'b111_000 press -> err_coord one cycle, no shot_valid, count unchanged.
REQ-037 shot_ready=0 for 10 cycles after valid, hh2 changed and second fire press meanwhile -> fields unchanged, valid held, single transfer after shot_ready=1, count +1 only.
REQ-038 Clear press during VALID -> clr_pulse one cycle, shot_valid 0, shot_count 0; simultaneous clear and fire press -> clr_pulse only.
REQ-039 17 accepted shots -> shot_count=15, no wrap.

Source files
------------

// File: rtl/modulo_captura_jogada.sv
// -----------------------------------------------------------------------------
// modulo_captura_jogada
//
// Captures one "shot" (line/column/mode) of the battleship game from the board
// switches when the fire pushbutton is pressed, and hands it to the
// attack-matrix stage over a valid/ready handshake.
//
// Every asynchronous input goes through a 2-flop synchronizer. Both buttons are
// debounced by a counter that must see DB_CYCLES consecutive cycles of a new
// level before the stable level follows it. A press is the 1->0 transition of
// the stable level (buttons are active-low).
//
// Ports
//   clk         system clock, all state on rising edge
//   clr         asynchronous active-low reset
//   button_clk  raw fire pushbutton, active-low
//   button_clr  raw clear pushbutton, active-low
//   hh1[1:0]    mode switches
//   hh2[5:0]    coordinate switches: [5:3] line, [2:0] column
//   shot_ready  downstream accepts the shot
//   shot_valid  captured shot available
//   shot_line   captured line 0..6
//   shot_col    captured column 0..4
//   shot_mode   captured hh1
//   err_coord   one-cycle pulse: out-of-board coordinate rejected
//   clr_pulse   one-cycle pulse: debounced clear press
//   shot_count  accepted shots, saturating at 15
// -----------------------------------------------------------------------------
module modulo_captura_jogada #(
    parameter int unsigned DB_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       button_clk,
    input  logic       button_clr,
    input  logic [1:0] hh1,
    input  logic [5:0] hh2,
    input  logic       shot_ready,
    output logic       shot_valid,
    output logic [2:0] shot_line,
    output logic [2:0] shot_col,
    output logic [1:0] shot_mode,
    output logic       err_coord,
    output logic       clr_pulse,
    output logic [3:0] shot_count
);

    typedef enum logic [1:0] {
        IDLE,
        VALID,
        WAIT_REL
    } state_t;

    localparam int unsigned CNT_W   = 20;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [2:0] LINE_MAX = 3'd6;
    localparam logic [2:0] COL_MAX  = 3'd4;

    // Button vectors: bit 0 = fire, bit 1 = clear.
    logic [1:0] btn_meta;
    logic [1:0] btn_sync;
    logic [1:0] btn_stable;
    logic [1:0] btn_press;
    logic [1:0] hh1_meta;
    logic [1:0] hh1_sync;
    logic [5:0] hh2_meta;
    logic [5:0] hh2_sync;

    // -------------------------------------------------------------------------
    // Synchronizers
    // -------------------------------------------------------------------------
    // NOTE: flops use non-blocking assignments so every register samples the
    // value from before the edge; blocking here would collapse the two stages.
    // NOTE: button stages reset to the released level (1) so that leaving
    // reset with the buttons up can never look like a press.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            btn_meta <= 2'b11;
            btn_sync <= 2'b11;
            hh1_meta <= '0;
            hh1_sync <= '0;
            hh2_meta <= '0;
            hh2_sync <= '0;
        end else begin
            btn_meta <= {button_clr, button_clk};
            btn_sync <= btn_meta;
            hh1_meta <= hh1;
            hh1_sync <= hh1_meta;
            hh2_meta <= hh2;
            hh2_sync <= hh2_meta;
        end
    end

    // -------------------------------------------------------------------------
    // Debouncers, one per button
    // -------------------------------------------------------------------------
    for (genvar b = 0; b < 2; b++) begin : g_db
        logic [CNT_W-1:0] cnt;
        logic             stable;
        logic             stable_d;

        always_ff @(posedge clk or negedge clr) begin
            if (!clr) begin
                cnt      <= '0;
                stable   <= 1'b1;
                stable_d <= 1'b1;
            end else begin
                stable_d <= stable;
                if (btn_sync[b] == stable) begin
                    cnt <= '0;
                end else if (cnt == DB_LAST) begin
                    stable <= btn_sync[b];
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign btn_stable[b] = stable;
        // Press event is the cycle in which the stable level has just become 0.
        assign btn_press[b]  = stable_d & ~stable;
    end

    logic fire_stable;
    logic fire_press;
    logic clear_press;
    logic coord_ok;

    assign fire_stable = btn_stable[0];
    assign fire_press  = btn_press[0];
    assign clear_press = btn_press[1];
    assign coord_ok    = (hh2_sync[5:3] <= LINE_MAX) && (hh2_sync[2:0] <= COL_MAX);

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    state_t state;
    state_t state_next;
    logic   capture;
    logic   reject;
    logic   transfer;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_next;
    end

    // A transfer completes on the handshake even when a clear arrives in the
    // same cycle; the clear only overrides the next state and the count.
    assign transfer = (state == VALID) && shot_ready;

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        reject     = 1'b0;
        if (clear_press) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fire_press) begin
                        if (coord_ok) begin
                            capture    = 1'b1;
                            state_next = VALID;
                        end else begin
                            reject     = 1'b1;
                            state_next = WAIT_REL;
                        end
                    end
                end
                VALID: begin
                    if (shot_ready) state_next = fire_stable ? IDLE : WAIT_REL;
                end
                WAIT_REL: begin
                    if (fire_stable) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign shot_valid = (state == VALID);

    // -------------------------------------------------------------------------
    // Shot fields, pulses and counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            shot_line  <= '0;
            shot_col   <= '0;
            shot_mode  <= '0;
            err_coord  <= 1'b0;
            clr_pulse  <= 1'b0;
            shot_count <= '0;
        end else begin
            err_coord <= reject;
            clr_pulse <= clear_press;
            if (capture) begin
                shot_line <= hh2_sync[5:3];
                shot_col  <= hh2_sync[2:0];
                shot_mode <= hh1_sync;
            end
            if (clear_press) begin
                shot_count <= '0;
            end else if (transfer && (shot_count != 4'hF)) begin
                shot_count <= shot_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_modulo_captura_jogada.sv
// -----------------------------------------------------------------------------
// tb_modulo_captura_jogada
//
// Directed bench for modulo_captura_jogada with DB_CYCLES = 4. The stimulus
// process pushes the expected shot / error / clear events into a scoreboard
// queue; a monitor on the falling edge pops and compares every handshake
// transfer, err_coord pulse and clr_pulse the DUT produces.
// -----------------------------------------------------------------------------
module tb_modulo_captura_jogada;

    localparam int DB = 4;

    typedef enum int {EV_SHOT, EV_ERR, EV_CLR} ev_t;
    typedef struct {
        ev_t kind;
        int  line;
        int  col;
        int  mode;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr;
    logic       button_clk;
    logic       button_clr;
    logic [1:0] hh1;
    logic [5:0] hh2;
    logic       shot_ready;
    logic       shot_valid;
    logic [2:0] shot_line;
    logic [2:0] shot_col;
    logic [1:0] shot_mode;
    logic       err_coord;
    logic       clr_pulse;
    logic [3:0] shot_count;

    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_count = 0;
    exp_t sb[$];
    exp_t mon_item;

    modulo_captura_jogada #(.DB_CYCLES(DB)) dut (
        .clk        (clk),
        .clr        (clr),
        .button_clk (button_clk),
        .button_clr (button_clr),
        .hh1        (hh1),
        .hh2        (hh2),
        .shot_ready (shot_ready),
        .shot_valid (shot_valid),
        .shot_line  (shot_line),
        .shot_col   (shot_col),
        .shot_mode  (shot_mode),
        .err_coord  (err_coord),
        .clr_pulse  (clr_pulse),
        .shot_count (shot_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic push_ev(input ev_t k, input int l, input int c, input int m);
        exp_t e;
        e.kind = k;
        e.line = l;
        e.col  = c;
        e.mode = m;
        sb.push_back(e);
    endtask

    // One clock step; inputs change 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic fire(input int hold, input int settle);
        button_clk = 1'b0;
        repeat (hold) step();
        button_clk = 1'b1;
        repeat (settle) step();
    endtask

    task automatic clear_btn(input int hold, input int settle);
        button_clr = 1'b0;
        repeat (hold) step();
        button_clr = 1'b1;
        repeat (settle) step();
    endtask

    // -------------------------------------------------------------------------
    // Monitor: sampled on the falling edge, away from the active edge.
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        if (clr) begin
            if (shot_valid && shot_ready) begin
                check("shot_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    mon_item = sb.pop_front();
                    check("shot_kind", int'(mon_item.kind), int'(EV_SHOT));
                    check("shot_line", int'(shot_line), mon_item.line);
                    check("shot_col",  int'(shot_col),  mon_item.col);
                    check("shot_mode", int'(shot_mode), mon_item.mode);
                end
            end
            if (err_coord) begin
                check("err_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    mon_item = sb.pop_front();
                    check("err_kind", int'(mon_item.kind), int'(EV_ERR));
                end
            end
            if (clr_pulse) begin
                check("clr_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    mon_item = sb.pop_front();
                    check("clr_kind", int'(mon_item.kind), int'(EV_CLR));
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int lat;

        clr        = 1'b0;
        button_clk = 1'b1;
        button_clr = 1'b1;
        hh1        = '0;
        hh2        = '0;
        shot_ready = 1'b0;
        step();

        // Reset with random inputs: every output must stay 0.
        for (int i = 0; i < 5; i++) begin
            button_clk = 1'($urandom);
            button_clr = 1'($urandom);
            hh1        = 2'($urandom);
            hh2        = 6'($urandom);
            shot_ready = 1'($urandom);
            step();
            check("reset_outputs",
                  int'({shot_valid, shot_line, shot_col, shot_mode, err_coord, clr_pulse, shot_count}), 0);
        end

        // Release with buttons up: no events for 50 cycles.
        button_clk = 1'b1;
        button_clr = 1'b1;
        shot_ready = 1'b1;
        step();
        clr = 1'b1;
        repeat (50) step();
        check("post_reset_valid", int'(shot_valid), 0);
        check("post_reset_count", int'(shot_count), 0);

        // Basic shot with latency measurement.
        hh2 = 6'b010_011;
        hh1 = 2'b01;
        repeat (4) step();
        push_ev(EV_SHOT, 2, 3, 1);
        button_clk = 1'b0;
        lat = 0;
        while (!shot_valid && lat < 20) begin
            step();
            lat++;
        end
        check("press_latency_window", int'(lat >= 2 + DB && lat <= 2 + DB + 2), 1);
        if (lat < 12) repeat (12 - lat) step();
        button_clk = 1'b1;
        repeat (12) step();
        exp_count = 1;
        check("count_after_first", int'(shot_count), exp_count);
        check("valid_after_first", int'(shot_valid), 0);

        // Bouncing fire button, then a clean hold: exactly one shot at the
        // board corner.
        hh2 = 6'b110_100;
        hh1 = 2'b11;
        repeat (4) step();
        push_ev(EV_SHOT, 6, 4, 3);
        for (int i = 0; i < 10; i++) begin
            button_clk = ~button_clk;
            repeat (2) step();
        end
        fire(12, 12);
        exp_count = 2;
        check("count_after_bounce", int'(shot_count), exp_count);

        // Out-of-board coordinates: line 7, then column 5.
        hh2 = 6'b111_000;
        repeat (4) step();
        push_ev(EV_ERR, 0, 0, 0);
        fire(12, 12);
        check("count_after_bad_line", int'(shot_count), exp_count);
        check("valid_after_bad_line", int'(shot_valid), 0);
        hh2 = 6'b000_101;
        repeat (4) step();
        push_ev(EV_ERR, 0, 0, 0);
        fire(12, 12);
        check("count_after_bad_col", int'(shot_count), exp_count);

        // Backpressure: fields frozen, second press ignored.
        shot_ready = 1'b0;
        hh2 = 6'b001_010;
        hh1 = 2'b10;
        repeat (4) step();
        push_ev(EV_SHOT, 1, 2, 2);
        fire(12, 10);
        check("held_valid", int'(shot_valid), 1);
        hh2 = 6'b011_001;
        hh1 = 2'b00;
        fire(12, 10);
        check("held_valid_after_press", int'(shot_valid), 1);
        check("held_line", int'(shot_line), 1);
        check("held_col",  int'(shot_col),  2);
        check("held_mode", int'(shot_mode), 2);
        check("held_count", int'(shot_count), exp_count);
        shot_ready = 1'b1;
        repeat (3) step();
        exp_count = 3;
        check("count_after_backpressure", int'(shot_count), exp_count);
        check("valid_after_backpressure", int'(shot_valid), 0);
        repeat (10) step();

        // Clear while a shot is pending.
        shot_ready = 1'b0;
        hh2 = 6'b000_000;
        repeat (4) step();
        fire(12, 10);
        check("valid_before_clear", int'(shot_valid), 1);
        push_ev(EV_CLR, 0, 0, 0);
        clear_btn(12, 12);
        exp_count = 0;
        check("valid_after_clear", int'(shot_valid), 0);
        check("count_after_clear", int'(shot_count), exp_count);

        // Clear and fire pressed together: only the clear takes effect.
        shot_ready = 1'b1;
        push_ev(EV_CLR, 0, 0, 0);
        button_clk = 1'b0;
        button_clr = 1'b0;
        repeat (12) step();
        button_clk = 1'b1;
        button_clr = 1'b1;
        repeat (12) step();
        check("valid_after_both", int'(shot_valid), 0);
        check("count_after_both", int'(shot_count), exp_count);

        // 17 accepted shots: counter saturates at 15.
        for (int i = 0; i < 17; i++) begin
            hh2 = {3'(i % 7), 3'(i % 5)};
            hh1 = 2'(i % 4);
            repeat (3) step();
            push_ev(EV_SHOT, i % 7, i % 5, i % 4);
            fire(8, 10);
            if (exp_count < 15) exp_count++;
            check("count_saturation", int'(shot_count), exp_count);
        end

        repeat (5) step();
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
